// File: rtl/max7219_rx.sv
// MAX7219 device-side receiver: synchronises sck/din/load, assembles 16-bit frames and decodes register writes.
// Optional daisy-chain output dout is enabled with `define MAX7219_DOUT_EN.
module max7219_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        sck,
   input  logic        din,
   input  logic        load,
   output logic [63:0] digits,
   output logic [7:0]  decode_mode,
   output logic [3:0]  intensity,
   output logic [2:0]  scan_limit,
   output logic        shutdown_n,
   output logic        disp_test,
   output logic        wr_valid,
   output logic [3:0]  wr_addr,
   output logic [7:0]  wr_data,
   output logic        frame_err
`ifdef MAX7219_DOUT_EN
   ,
   output logic        dout
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
   logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;
   logic                   sck_prev_q, sck_prev_d;
   logic                   load_prev_q, load_prev_d;
   logic                   fall_pend_q, fall_pend_d;
   logic [15:0]            shift_q, shift_d;
   logic [4:0]             bit_cnt_q, bit_cnt_d;
   logic [63:0]            digits_q, digits_d;
   logic [7:0]             decode_mode_q, decode_mode_d;
   logic [3:0]             intensity_q, intensity_d;
   logic [2:0]             scan_limit_q, scan_limit_d;
   logic                   shutdown_n_q, shutdown_n_d;
   logic                   disp_test_q, disp_test_d;
   logic                   wr_valid_q, wr_valid_d;
   logic [3:0]             wr_addr_q, wr_addr_d;
   logic [7:0]             wr_data_q, wr_data_d;
   logic                   frame_err_q, frame_err_d;
   logic                   sck_s, din_s, load_s;
   logic                   sck_rise, load_rise, load_fall;
   logic [3:0]             addr_s;
   logic [7:0]             data_s;
`ifdef MAX7219_DOUT_EN
   logic                   dout_q, dout_d;
   logic                   sck_fall;
`endif

   // Synchroniser chains and edge-detect history.
   always_comb begin
      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
      din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], din};
      load_sync_d = {load_sync_q[SYNC_STAGES-2:0], load};
      sck_s       = sck_sync_q[SYNC_STAGES-1];
      din_s       = din_sync_q[SYNC_STAGES-1];
      load_s      = load_sync_q[SYNC_STAGES-1];
      sck_prev_d  = sck_s;
      load_prev_d = load_s;
      sck_rise    = sck_s & ~sck_prev_q;
      load_rise   = load_s & ~load_prev_q;
      load_fall   = ~load_s & load_prev_q;
      addr_s      = shift_q[11:8];
      data_s      = shift_q[7:0];
   end

   // Frame FSM, shift register and register-file decode.
   always_comb begin
      state_d       = state_q;
      shift_d       = shift_q;
      bit_cnt_d     = bit_cnt_q;
      fall_pend_d   = 1'b0;
      digits_d      = digits_q;
      decode_mode_d = decode_mode_q;
      intensity_d   = intensity_q;
      scan_limit_d  = scan_limit_q;
      shutdown_n_d  = shutdown_n_q;
      disp_test_d   = disp_test_q;
      wr_valid_d    = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      frame_err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A load fall seen during COMMIT is remembered so back-to-back frames are not lost.
            if (load_fall || fall_pend_q) begin
               state_d   = ST_SHIFT;
               bit_cnt_d = 5'd0;
`ifndef MAX7219_DOUT_EN
               shift_d   = 16'd0;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (sck_rise) begin
               shift_d = {shift_q[14:0], din_s};
               if (bit_cnt_q != 5'd16) begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end else begin
                  bit_cnt_d = bit_cnt_q;
               end
            end else begin
               shift_d = shift_q;
            end
            if (load_rise) begin
               state_d = ST_COMMIT;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_COMMIT: begin
            state_d     = ST_IDLE;
            fall_pend_d = load_fall;
            if (bit_cnt_q == 5'd16) begin
               wr_valid_d = 1'b1;
               wr_addr_d  = addr_s;
               wr_data_d  = data_s;
               case (addr_s)
                  4'h9:    decode_mode_d = data_s;
                  4'hA:    intensity_d   = data_s[3:0];
                  4'hB:    scan_limit_d  = data_s[2:0];
                  4'hC:    shutdown_n_d  = data_s[0];
                  4'hF:    disp_test_d   = data_s[0];
                  default: begin
                     // 0x1..0x8 select a digit; 0x0, 0xD and 0xE match nothing here.
                     for (int i = 0; i < 8; i++) begin
                        if (addr_s == 4'(i + 1)) begin
                           digits_d[8*i +: 8] = data_s;
                        end else begin
                           digits_d[8*i +: 8] = digits_d[8*i +: 8];
                        end
                     end
                  end
               endcase
            end else begin
               frame_err_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef MAX7219_DOUT_EN
   // Daisy-chain output: MSB of the shifter presented on each sck falling edge.
   always_comb begin
      sck_fall = ~sck_s & sck_prev_q;
      if (state_q == ST_IDLE) begin
         dout_d = 1'b0;
      end else if (sck_fall) begin
         dout_d = shift_q[15];
      end else begin
         dout_d = dout_q;
      end
   end

   // Daisy-chain output register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dout_q <= 1'b0;
      end else begin
         dout_q <= dout_d;
      end
   end

   assign dout = dout_q;
`endif

   // State register; load sync resets low so a load held low across reset starts no frame.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         sck_sync_q    <= '0;
         din_sync_q    <= '0;
         load_sync_q   <= '0;
         sck_prev_q    <= 1'b0;
         load_prev_q   <= 1'b0;
         fall_pend_q   <= 1'b0;
         shift_q       <= 16'd0;
         bit_cnt_q     <= 5'd0;
         digits_q      <= 64'd0;
         decode_mode_q <= 8'd0;
         intensity_q   <= 4'd0;
         scan_limit_q  <= 3'd0;
         shutdown_n_q  <= 1'b0;
         disp_test_q   <= 1'b0;
         wr_valid_q    <= 1'b0;
         wr_addr_q     <= 4'd0;
         wr_data_q     <= 8'd0;
         frame_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         sck_sync_q    <= sck_sync_d;
         din_sync_q    <= din_sync_d;
         load_sync_q   <= load_sync_d;
         sck_prev_q    <= sck_prev_d;
         load_prev_q   <= load_prev_d;
         fall_pend_q   <= fall_pend_d;
         shift_q       <= shift_d;
         bit_cnt_q     <= bit_cnt_d;
         digits_q      <= digits_d;
         decode_mode_q <= decode_mode_d;
         intensity_q   <= intensity_d;
         scan_limit_q  <= scan_limit_d;
         shutdown_n_q  <= shutdown_n_d;
         disp_test_q   <= disp_test_d;
         wr_valid_q    <= wr_valid_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         frame_err_q   <= frame_err_d;
      end
   end

   assign digits      = digits_q;
   assign decode_mode = decode_mode_q;
   assign intensity   = intensity_q;
   assign scan_limit  = scan_limit_q;
   assign shutdown_n  = shutdown_n_q;
   assign disp_test   = disp_test_q;
   assign wr_valid    = wr_valid_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_max7219_rx.sv
// Directed bench for max7219_rx: serial frames driven bit by bit, commits checked against a scoreboard and register model.
module tb_max7219_rx;

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   logic        sck   = 1'b0;
   logic        din   = 1'b0;
   logic        load  = 1'b1;
   logic [63:0] digits;
   logic [7:0]  decode_mode;
   logic [3:0]  intensity;
   logic [2:0]  scan_limit;
   logic        shutdown_n;
   logic        disp_test;
   logic        wr_valid;
   logic [3:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        frame_err;
`ifdef MAX7219_DOUT_EN
   logic        dout;
   logic [15:0] dout_log = 16'd0;
   logic [31:0] stream;
`endif

   int          tests_run = 0;
   int          fails     = 0;
   int          wr_cnt    = 0;
   int          ferr_cnt  = 0;
   logic [11:0] exp_q[$];
   logic [11:0] e;

   logic [63:0] m_digits = 64'd0;
   logic [7:0]  m_dm     = 8'd0;
   logic [3:0]  m_int    = 4'd0;
   logic [2:0]  m_scan   = 3'd0;
   logic        m_shdn   = 1'b0;
   logic        m_test   = 1'b0;
   logic [3:0]  m_waddr  = 4'd0;
   logic [7:0]  m_wdata  = 8'd0;
   logic [7:0]  dig_data [8] = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'h11, 8'h22, 8'hAA};

   max7219_rx #(.SYNC_STAGES(2)) dut (
      .clock      (clock),
      .reset      (rst_n),
      .sck        (sck),
      .din        (din),
      .load       (load),
      .digits     (digits),
      .decode_mode(decode_mode),
      .intensity  (intensity),
      .scan_limit (scan_limit),
      .shutdown_n (shutdown_n),
      .disp_test  (disp_test),
      .wr_valid   (wr_valid),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .frame_err  (frame_err)
`ifdef MAX7219_DOUT_EN
      ,
      .dout       (dout)
`endif
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_wr(input logic [3:0] a, input logic [7:0] d);
      m_waddr = a;
      m_wdata = d;
      case (a)
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: m_digits[8*(int'(a)-1) +: 8] = d;
         4'h9:    m_dm   = d;
         4'hA:    m_int  = d[3:0];
         4'hB:    m_scan = d[2:0];
         4'hC:    m_shdn = d[0];
         4'hF:    m_test = d[0];
         default: m_waddr = a;
      endcase
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Shifts n bits of v MSB first; when finish is set, load rises and the commit window elapses.
   task automatic send_bits(input logic [31:0] v, input int n, input bit finish);
      load = 1'b0;
      wait_clk(6);
      for (int i = n - 1; i >= 0; i--) begin
         din = v[i];
         wait_clk(6);
         sck = 1'b1;
         wait_clk(6);
         sck = 1'b0;
         wait_clk(6);
`ifdef MAX7219_DOUT_EN
         dout_log = {dout_log[14:0], dout};
`endif
      end
      if (finish) begin
         load = 1'b1;
         wait_clk(10);
      end
   endtask

   task automatic send_frame(input logic [15:0] f);
      exp_q.push_back(f[11:0]);
      model_wr(f[11:8], f[7:0]);
      send_bits({16'd0, f}, 16, 1'b1);
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".digits"},      digits,      m_digits);
      chk({tag, ".decode_mode"}, decode_mode, m_dm);
      chk({tag, ".intensity"},   intensity,   m_int);
      chk({tag, ".scan_limit"},  scan_limit,  m_scan);
      chk({tag, ".shutdown_n"},  shutdown_n,  m_shdn);
      chk({tag, ".disp_test"},   disp_test,   m_test);
      chk({tag, ".wr_addr"},     wr_addr,     m_waddr);
      chk({tag, ".wr_data"},     wr_data,     m_wdata);
      chk({tag, ".wr_valid"},    wr_valid,    1'b0);
      chk({tag, ".frame_err"},   frame_err,   1'b0);
   endtask

   // Scoreboard: every wr_valid pulse must match the oldest pending frame.
   always @(negedge clock) begin
      if (rst_n && wr_valid === 1'b1) begin
         wr_cnt++;
         chk("wr_expected", exp_q.size() > 0, 1'b1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_wr_addr", wr_addr, e[11:8]);
            chk("sb_wr_data", wr_data, e[7:0]);
         end
      end
      if (rst_n && frame_err === 1'b1) begin
         ferr_cnt++;
      end
   end

   initial begin
      wait_clk(5);
      rst_n = 1'b1;
      wait_clk(20);
      check_regs("reset");
      chk("reset.wr_cnt", wr_cnt, 0);

      send_frame(16'h0C01);
      send_frame(16'h0A07);
      send_frame(16'h0B07);
      send_frame(16'h0900);
      check_regs("config");
      chk("config.shutdown_n_on", shutdown_n, 1'b1);
      chk("config.wr_cnt", wr_cnt, 4);

      for (int i = 0; i < 8; i++) begin
         send_frame({4'h0, 4'(i + 1), dig_data[i]});
      end
      check_regs("digits");
      chk("digits.lsb", digits[7:0], 8'h55);
      chk("digits.msb", digits[63:56], 8'hAA);
      chk("digits.wr_cnt", wr_cnt, 12);

      exp_q.push_back(12'hA3C);
      model_wr(4'hA, 8'h3C);
      send_bits(32'h000F0A3C, 20, 1'b1);
      check_regs("burst20");
      chk("burst20.intensity", intensity, 4'hC);
      chk("burst20.ferr_cnt", ferr_cnt, 0);
      chk("burst20.wr_cnt", wr_cnt, 13);

      send_bits(32'h000002A5, 10, 1'b1);
      check_regs("short10");
      chk("short10.ferr_cnt", ferr_cnt, 1);
      chk("short10.wr_cnt", wr_cnt, 13);

      send_bits(32'h000000C1, 8, 1'b0);
      rst_n = 1'b0;
      m_digits = 64'd0; m_dm = 8'd0; m_int = 4'd0; m_scan = 3'd0;
      m_shdn = 1'b0; m_test = 1'b0; m_waddr = 4'd0; m_wdata = 8'd0;
      wait_clk(4);
      rst_n = 1'b1;
      wait_clk(10);
      load = 1'b1;
      wait_clk(12);
      check_regs("midreset");
      chk("midreset.wr_cnt", wr_cnt, 13);
      chk("midreset.ferr_cnt", ferr_cnt, 1);

`ifdef MAX7219_DOUT_EN
      send_frame(16'h0301);
      send_frame(16'h0402);
      stream = {16'h0301, 16'h0402};
      chk("dout.replay", dout_log, stream[30:15]);
      chk("dout.idle", dout, 1'b0);
`else
      send_frame(16'h0C01);
`endif
      check_regs("final");
      chk("final.queue_drained", exp_q.size(), 0);
      chk("final.ferr_cnt", ferr_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #2000000;
      fails++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
